// File: rtl/shift_reg_pkg.sv
// Shared constants for the shift-register sequencer and its downstream register.
package shift_reg_pkg;

    localparam logic [1:0] CTRL_LOAD = 2'b00;
    localparam logic [1:0] CTRL_SHR  = 2'b01;
    localparam logic [1:0] CTRL_SHL  = 2'b10;
    localparam logic [1:0] CTRL_HOLD = 2'b11;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [1:0] shift_ctrl(input logic dir);
        return (dir == DIR_LEFT) ? CTRL_SHL : CTRL_SHR;
    endfunction

endpackage

// File: rtl/shift_reg_sequencer.sv
// Drives a universal shift register through load, DW shifts and a done pulse,
// turning one parallel word into a serial stream (LSB- or MSB-first).
//
// state | meaning
// IDLE  | in_ready high, register held, waiting for a word
// LOAD  | register loads the captured word this cycle
// SHIFT | DW shift cycles, serial-end bit valid each cycle
// DONE  | one-cycle done pulse, register held
module shift_reg_sequencer
    import shift_reg_pkg::*;
#(
    parameter  int DW = 4,
    localparam int CW = $clog2(DW)
) (
    input  logic          clk,
    input  logic          async_rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_dir,
    input  logic          in_fill,
    input  logic          abort,
    output logic [1:0]    sr_ctrl,
    output logic [DW-1:0] sr_data,
    output logic          sr_data_l,
    output logic          sr_data_h,
    output logic          ser_valid,
    output logic          ser_last,
    output logic          busy,
    output logic          done
);

    state_t        state;
    logic          dir;
    logic          fill;
    logic [CW-1:0] cnt;
    logic          abort_now;

    assign abort_now = abort && (state == LOAD || state == SHIFT);

    // Every output is registered and computed for the state being entered.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state     <= IDLE;
            dir       <= 1'b0;
            fill      <= 1'b0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            sr_ctrl   <= CTRL_HOLD;
            sr_data   <= '0;
            sr_data_l <= 1'b0;
            sr_data_h <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort_now) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            sr_ctrl   <= CTRL_HOLD;
            sr_data_l <= 1'b0;
            sr_data_h <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state    <= LOAD;
                        sr_data  <= in_data;
                        dir      <= in_dir;
                        fill     <= in_fill;
                        in_ready <= 1'b0;
                        sr_ctrl  <= CTRL_LOAD;
                        busy     <= 1'b1;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    state     <= SHIFT;
                    cnt       <= CW'(DW - 1);
                    sr_ctrl   <= shift_ctrl(dir);
                    sr_data_h <= (dir == DIR_RIGHT) ? fill : 1'b0;
                    sr_data_l <= (dir == DIR_LEFT)  ? fill : 1'b0;
                    ser_valid <= 1'b1;
                    ser_last  <= 1'b0;
                end
                SHIFT: begin
                    if (cnt == '0) begin
                        state     <= DONE;
                        sr_ctrl   <= CTRL_HOLD;
                        sr_data_l <= 1'b0;
                        sr_data_h <= 1'b0;
                        ser_valid <= 1'b0;
                        ser_last  <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        cnt      <= cnt - CW'(1);
                        ser_last <= (cnt == CW'(1));
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    sr_ctrl  <= CTRL_HOLD;
                    busy     <= 1'b0;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench: sequencer feeding a behavioural 4-bit universal shift register.
module tb_shift_reg_sequencer;
    import shift_reg_pkg::*;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          async_rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_dir = 1'b0;
    logic          in_fill = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic [1:0]    sr_ctrl;
    logic [DW-1:0] sr_data;
    logic          sr_data_l, sr_data_h, ser_valid, ser_last, busy, done;
    logic [DW-1:0] q;

    int checks = 0;
    int errors = 0;

    shift_reg_sequencer #(.DW(DW)) dut (
        .clk(clk), .async_rst_n(async_rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dir(in_dir), .in_fill(in_fill), .abort(abort),
        .sr_ctrl(sr_ctrl), .sr_data(sr_data), .sr_data_l(sr_data_l), .sr_data_h(sr_data_h),
        .ser_valid(ser_valid), .ser_last(ser_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Downstream universal shift register model
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) q <= '0;
        else begin
            case (sr_ctrl)
                CTRL_LOAD: q <= sr_data;
                CTRL_SHR:  q <= {sr_data_h, q[DW-1:1]};
                CTRL_SHL:  q <= {q[DW-2:0], sr_data_l};
                default:   q <= q;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready timeout: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_reset();
        async_rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (sr_ctrl !== CTRL_HOLD) begin errors++; $display("FAIL reset_sr_ctrl: got %b required 11", sr_ctrl); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        checks++; if ({busy, done, ser_valid, ser_last} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b required 0000", {busy, done, ser_valid, ser_last}); end
        checks++; if ({sr_data, sr_data_l, sr_data_h} !== 6'b0) begin errors++; $display("FAIL reset_data: got %b required 0", {sr_data, sr_data_l, sr_data_h}); end
        #2 async_rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b required 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b required 0", busy); end
    endtask

    task automatic test_shift_right();
        logic exp_ser [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        in_data = 4'b1011; in_dir = 1'b0; in_fill = 1'b0; in_valid = 1'b1;
        checks++; if (sr_ctrl !== CTRL_HOLD) begin errors++; $display("FAIL shr_idle_ctrl: got %b required 11", sr_ctrl); end
        tick();
        in_valid = 1'b0; in_data = 4'b0000; in_dir = 1'b1; in_fill = 1'b1;
        checks++; if (sr_ctrl !== CTRL_LOAD) begin errors++; $display("FAIL shr_load_ctrl: got %b required 00", sr_ctrl); end
        checks++; if ({busy, in_ready} !== 2'b10) begin errors++; $display("FAIL shr_load_busy_ready: got %b required 10", {busy, in_ready}); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (sr_ctrl !== CTRL_SHR) begin errors++; $display("FAIL shr_ctrl[%0d]: got %b required 01", k, sr_ctrl); end
            checks++; if (ser_valid !== 1'b1) begin errors++; $display("FAIL shr_ser_valid[%0d]: got %b required 1", k, ser_valid); end
            checks++; if (q[0] !== exp_ser[k]) begin errors++; $display("FAIL shr_serial_bit[%0d]: got %b required %b", k, q[0], exp_ser[k]); end
            checks++; if (ser_last !== (k == 3)) begin errors++; $display("FAIL shr_ser_last[%0d]: got %b required %b", k, ser_last, (k == 3)); end
            checks++; if ({sr_data_h, sr_data_l} !== 2'b00) begin errors++; $display("FAIL shr_fill[%0d]: got %b required 00", k, {sr_data_h, sr_data_l}); end
        end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL shr_done: got %b required 1", done); end
        checks++; if (sr_ctrl !== CTRL_HOLD) begin errors++; $display("FAIL shr_done_ctrl: got %b required 11", sr_ctrl); end
        checks++; if ({ser_valid, in_ready} !== 2'b00) begin errors++; $display("FAIL shr_done_valid_ready: got %b required 00", {ser_valid, in_ready}); end
        checks++; if (q !== 4'b0000) begin errors++; $display("FAIL shr_final_q: got %b required 0000", q); end
        tick();
        checks++; if ({done, busy, in_ready} !== 3'b001) begin errors++; $display("FAIL shr_back_idle: got %b required 001", {done, busy, in_ready}); end
    endtask

    task automatic test_shift_left();
        logic exp_ser [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        in_data = 4'b1011; in_dir = 1'b1; in_fill = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_dir = 1'b0; in_fill = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (sr_ctrl !== CTRL_SHL) begin errors++; $display("FAIL shl_ctrl[%0d]: got %b required 10", k, sr_ctrl); end
            checks++; if (q[3] !== exp_ser[k]) begin errors++; $display("FAIL shl_serial_bit[%0d]: got %b required %b", k, q[3], exp_ser[k]); end
            checks++; if ({sr_data_l, sr_data_h} !== 2'b10) begin errors++; $display("FAIL shl_fill[%0d]: got l,h=%b required 10", k, {sr_data_l, sr_data_h}); end
        end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL shl_done: got %b required 1", done); end
        checks++; if (sr_data_l !== 1'b0) begin errors++; $display("FAIL shl_done_fill: got %b required 0", sr_data_l); end
        checks++; if (q !== 4'b1111) begin errors++; $display("FAIL shl_final_q: got %b required 1111", q); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic exp_ser [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic got_ser [8];
        int nbits = 0;
        int ready_cnt = 0;
        int gap = -1;
        in_data = 4'hA; in_dir = 1'b0; in_fill = 1'b0; in_valid = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            tick();
            if (i == 0) in_data = 4'h5;
            if (ser_valid === 1'b1 && nbits < 8) begin
                got_ser[nbits] = q[0];
                nbits++;
            end
            if (in_ready === 1'b1) begin
                ready_cnt++;
                if (gap < 0) gap = i + 1;
            end else if (gap >= 0) begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        checks++; if (ready_cnt != 1) begin errors++; $display("FAIL b2b_ready_pulses: got %0d required 1", ready_cnt); end
        checks++; if (gap != 7) begin errors++; $display("FAIL b2b_handshake_gap: got %0d required 7", gap); end
        checks++; if (nbits != 8) begin errors++; $display("FAIL b2b_bit_count: got %0d required 8", nbits); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (k < nbits && got_ser[k] !== exp_ser[k]) begin
                errors++; $display("FAIL b2b_serial_bit[%0d]: got %b required %b", k, got_ser[k], exp_ser[k]);
            end
        end
        wait_ready();
    endtask

    task automatic test_abort();
        in_data = 4'b1011; in_dir = 1'b0; in_fill = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        checks++; if (sr_ctrl !== CTRL_SHR) begin errors++; $display("FAIL abort_pre_ctrl: got %b required 01", sr_ctrl); end
        tick();
        abort = 1'b0;
        checks++; if ({busy, in_ready} !== 2'b01) begin errors++; $display("FAIL abort_idle: busy,ready=%b required 01", {busy, in_ready}); end
        checks++; if (sr_ctrl !== CTRL_HOLD) begin errors++; $display("FAIL abort_ctrl: got %b required 11", sr_ctrl); end
        checks++; if ({ser_valid, done} !== 2'b00) begin errors++; $display("FAIL abort_valid_done: got %b required 00", {ser_valid, done}); end
        checks++; if (q !== 4'b0010) begin errors++; $display("FAIL abort_q: got %b required 0010", q); end
        tick();
        checks++; if ({done, q} !== 5'b0_0010) begin errors++; $display("FAIL abort_hold: done,q=%b required 00010", {done, q}); end
    endtask

    task automatic test_async_reset();
        logic exp_ser [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        in_data = 4'b1011; in_dir = 1'b1; in_fill = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        #3 async_rst_n = 1'b0;
        #1;
        checks++; if (sr_ctrl !== CTRL_HOLD) begin errors++; $display("FAIL arst_ctrl: got %b required 11", sr_ctrl); end
        checks++; if ({busy, in_ready, ser_valid, ser_last, done} !== 5'b0) begin errors++; $display("FAIL arst_flags: got %b required 00000", {busy, in_ready, ser_valid, ser_last, done}); end
        #2 async_rst_n = 1'b1;
        tick();
        checks++; if ({busy, in_ready} !== 2'b01) begin errors++; $display("FAIL arst_release: busy,ready=%b required 01", {busy, in_ready}); end
        in_data = 4'b0110; in_dir = 1'b0; in_fill = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (q[0] !== exp_ser[k] || ser_valid !== 1'b1) begin errors++; $display("FAIL arst_serial_bit[%0d]: got %b valid %b required %b", k, q[0], ser_valid, exp_ser[k]); end
        end
        tick();
        checks++; if ({done, q} !== 5'b1_1111) begin errors++; $display("FAIL arst_final: done,q=%b required 11111", {done, q}); end
        tick();
    endtask

    task automatic test_abort_handshake();
        in_data = 4'b0110; in_dir = 1'b0; in_fill = 1'b0; in_valid = 1'b1; abort = 1'b1;
        tick();
        in_valid = 1'b0; abort = 1'b0;
        checks++; if (sr_ctrl !== CTRL_LOAD) begin errors++; $display("FAIL abort_hs_ctrl: got %b required 00", sr_ctrl); end
        checks++; if ({busy, in_ready} !== 2'b10) begin errors++; $display("FAIL abort_hs_busy: busy,ready=%b required 10", {busy, in_ready}); end
        repeat (5) tick();
        checks++; if ({done, q} !== 5'b1_0000) begin errors++; $display("FAIL abort_hs_done: done,q=%b required 10000", {done, q}); end
        tick();
    endtask

    initial begin
        test_reset();
        test_shift_right();
        test_shift_left();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_abort_handshake();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
